nibble_shift_driver: RTL and testbench
======================================

# nibble_shift_driver

Upstream control stage for the 4-bit parallel-load shift register. It accepts one word at a time over a valid/ready handshake and delivers it to the register either as a single parallel-load strobe or as a serial bit stream on the register's serial input. It then waits a fixed settle time, pulses `done`, and counts delivered words. One instance drives one shift register; its `load`, `l_out` and `ser_out` outputs connect directly to that register's Load, L and serial inputs.

## Interface
- `WIDTH`, default 4: word width; must match the downstream register width.
- `SETTLE_CYCLES`, default 2: idle cycles after delivery that cover the downstream register latency; legal range 1–15.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: upstream word available.
- `in_data`  in  WIDTH: word to deliver; bit index 0 corresponds to downstream register position 0.
- `in_mode`  in  1: delivery mode, 0 = parallel load, 1 = serial shift; sampled together with `in_data`.
- `in_ready`  out  1: block can accept a word this cycle.
- `load`  out  1: downstream parallel-load strobe.
- `l_out`  out  WIDTH: downstream parallel-load data.
- `ser_out`  out  1: downstream serial input.
- `done`  out  1: one-cycle pulse when a word's delivery and settle time are complete.
- `word_cnt`  out  8: number of completed words.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - LOAD: exactly 1 cycle.
  - SHIFT: WIDTH cycles, tracked by a bit counter.
  - SETTLE: SETTLE_CYCLES cycles, tracked by a settle counter.
- Accept: on a rising edge where `in_valid`=1 and `in_ready`=1, register `in_data` and `in_mode`.
  - `in_mode`=0: next state LOAD.
  - `in_mode`=1: next state SHIFT.
- `in_valid` outside IDLE is ignored; `in_data` is not sampled.
- LOAD: `load`=1 and `l_out`=captured word; then SETTLE.
- SHIFT, cycle k (k = 0..WIDTH-1):
  - `load`=0, `ser_out`=word[WIDTH-1-k], so word[WIDTH-1] is sent first.
  - After WIDTH shifts the downstream register holds the word in index order.
  - After cycle WIDTH-1: SETTLE.
- SETTLE: `load`=0, `ser_out`=0, `l_out`=0.
  - In the last settle cycle, `done`=1 and `word_cnt` increments at the end of that cycle.
  - Next state is IDLE.
- Output defaults:
  - `l_out`=0 in every state except LOAD.
  - `ser_out`=0 in every state except SHIFT.
  - `load`=1 only in LOAD.
- `word_cnt` is modulo 256: 255 → 0 with no flag.
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state = IDLE, all counters 0.
  - `load`=0, `l_out`=0, `ser_out`=0, `done`=0, `word_cnt`=0.
  - `in_ready`=0 while `rst_n`=0; `in_ready`=1 from the first cycle after release.
- Reset has priority over a simultaneous `in_valid`; no word is accepted in that cycle.
- Reset mid-operation (LOAD, SHIFT or SETTLE): the in-flight word is discarded, no `done` is issued, and `word_cnt` is cleared.
- Cycle 0 is the accept edge. Parallel mode:
  - `load`=1 in cycle 1.
  - `done` in cycle 1+SETTLE_CYCLES.
  - `in_ready`=1 in cycle 2+SETTLE_CYCLES.
- Serial mode:
  - `ser_out` carries bits in cycles 1..WIDTH.
  - `done` in cycle WIDTH+SETTLE_CYCLES.
  - `in_ready`=1 in cycle WIDTH+SETTLE_CYCLES+1.
- Back-to-back: a word can be accepted on the first edge with `in_ready`=1. There is no extra idle cycle beyond those listed above.
- `in_data` changing after the accept edge has no effect on delivery.

## Test plan
- Reset with `in_valid`=1 held through reset:
  - While `rst_n`=0: every output is 0 and no word is accepted.
  - Cycle after release: `in_ready`=1.
- Parallel, WIDTH=4, S=2, `in_data`=4'b1010, `in_mode`=0:
  - `load`=1 and `l_out`=1010 in cycle 1 only.
  - `done` in cycle 3; `word_cnt`=1.
  - `in_ready`=1 in cycle 4.
- Serial, `in_data`=4'b0110 (bit3..0), `in_mode`=1:
  - `ser_out` in cycles 1–4 = 0,1,1,0 (bits 3,2,1,0).
  - `load`=0 throughout.
  - `done` in cycle 6.
  - Downstream register reads 0110 after `done`.
- `in_valid` toggled with a new value (1111) during SHIFT: ignored; the stream is unchanged and only one `done` is issued.
- `rst_n` pulsed low in SHIFT cycle 2:
  - Next cycle: IDLE, `ser_out`=0, `word_cnt`=0, no `done`.
- 257 back-to-back words with mixed modes:
  - `word_cnt` wraps to 0 at word 256 and reads 1 after word 257.
  - Each `done` is exactly one cycle wide.

Source files
------------

// File: rtl/nibble_shift_driver.sv
// nibble_shift_driver
//   Front end for a WIDTH-bit parallel-load shift register. Takes one word per
//   valid/ready handshake and delivers it either as a single parallel-load
//   strobe or as an MSB-first serial stream. After delivery it waits
//   SETTLE_CYCLES cycles, pulses done, and bumps a modulo-256 word counter.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : upstream word available
//   in_data   : word to deliver (bit 0 = downstream position 0)
//   in_mode   : 0 = parallel load, 1 = serial shift
//   in_ready  : block can accept a word this cycle
//   load      : downstream parallel-load strobe
//   l_out     : downstream parallel-load data
//   ser_out   : downstream serial input
//   done      : one-cycle pulse at the end of the settle time
//   word_cnt  : completed word count, wraps 255 -> 0
//
// Every output is decoded from registered state only, so nothing on the
// input side reaches an output combinationally.
module nibble_shift_driver #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             in_ready,
    output logic             load,
    output logic [WIDTH-1:0] l_out,
    output logic             ser_out,
    output logic             done,
    output logic [7:0]       word_cnt
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, SETTLE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] word_q;
    logic [BW-1:0]    bit_cnt;
    logic [3:0]       settle_cnt;
    logic             rdy_q;
    logic             accept;
    logic             last_bit;
    logic             last_settle;

    assign accept      = in_valid && in_ready;
    assign last_bit    = (bit_cnt == BW'(WIDTH - 1));
    assign last_settle = (settle_cnt == 4'(SETTLE_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_mode ? SHIFT : LOAD;
            LOAD:    state_nxt = SETTLE;
            SHIFT:   if (last_bit) state_nxt = SETTLE;
            SETTLE:  if (last_settle) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rdy_q holds in_ready low for the whole reset period: state is already
    // IDLE after the first reset edge, but no word may be taken until the
    // first edge with rst_n released.
    always_comb begin
        in_ready = rdy_q && (state == IDLE);
        load     = (state == LOAD);
        l_out    = '0;
        ser_out  = 1'b0;
        done     = 1'b0;
        if (state == LOAD)   l_out   = word_q;
        // word_q shifts left each SHIFT cycle, so its MSB is always the next
        // bit to send.
        if (state == SHIFT)  ser_out = word_q[WIDTH-1];
        if (state == SETTLE) done    = last_settle;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            word_q     <= '0;
            bit_cnt    <= '0;
            settle_cnt <= '0;
            rdy_q      <= 1'b0;
            word_cnt   <= '0;
        end else begin
            state <= state_nxt;
            rdy_q <= 1'b1;

            if (accept) begin
                word_q  <= in_data;
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                word_q  <= word_q << 1;
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end

            if (state == SETTLE)
                settle_cnt <= last_settle ? 4'd0 : settle_cnt + 4'd1;

            if (done)
                word_cnt <= word_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_nibble_shift_driver.sv
// Bench for nibble_shift_driver (WIDTH=4, SETTLE_CYCLES=2).
// The driver pushes one record per accepted word; the monitor derives the
// expected per-cycle outputs from the record's accept cycle and the delivery
// timing rules, models the downstream register from load/ser_out, and pops
// the record on its done cycle.
module tb_nibble_shift_driver;

    localparam int W = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_mode;
    logic         in_ready;
    logic         load;
    logic [W-1:0] l_out;
    logic         ser_out;
    logic         done;
    logic [7:0]   word_cnt;

    nibble_shift_driver #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .in_ready (in_ready),
        .load     (load),
        .l_out    (l_out),
        .ser_out  (ser_out),
        .done     (done),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        bit           mode;
        int           acc;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    logic rst_q  = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] r);
        checks++;
        if (a !== r) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, a, r);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int           exp_cnt = 0;
    logic [W-1:0] ds = '0;

    always @(negedge clk) begin
        rec_t         h;
        int           rel;
        int           dlen;
        logic         e_load, e_ser, e_done, e_rdy;
        logic [W-1:0] e_l;
        bit           act;
        if (cyc >= 1) begin
            if (!rst_q) begin
                q.delete();
                exp_cnt = 0;
                ds      = '0;
                chk("rst_in_ready", in_ready, 0);
                chk("rst_load",     load,     0);
                chk("rst_l_out",    l_out,    0);
                chk("rst_ser_out",  ser_out,  0);
                chk("rst_done",     done,     0);
                chk("rst_word_cnt", word_cnt, 0);
            end else begin
                e_load = 0; e_ser = 0; e_done = 0; e_rdy = 1; e_l = '0;
                act = 0; rel = 0; dlen = 0;
                if (q.size() > 0) begin
                    h   = q[0];
                    rel = cyc - h.acc + 1;
                    if (rel >= 1) begin
                        act   = 1;
                        e_rdy = 0;
                        dlen  = h.mode ? W + S : 1 + S;
                        if (!h.mode && rel == 1) begin
                            e_load = 1;
                            e_l    = h.data;
                        end
                        if (h.mode && rel <= W) e_ser = h.data[W-rel];
                        e_done = (rel == dlen);
                    end
                end
                chk("in_ready", in_ready, e_rdy);
                chk("load",     load,     e_load);
                chk("l_out",    l_out,    e_l);
                chk("ser_out",  ser_out,  e_ser);
                chk("done",     done,     e_done);
                chk("word_cnt", word_cnt, exp_cnt);
                // downstream register: parallel load or shift toward MSB
                if (load === 1'b1) ds = l_out;
                else if (act && h.mode && rel <= W) ds = {ds[W-2:0], ser_out};
                if (e_done) begin
                    chk("ds_word", ds, h.data);
                    exp_cnt = (exp_cnt + 1) % 256;
                    void'(q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [W-1:0] d, input bit m);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        t = 0;
        while (!(in_ready === 1'b1 && rst_n) && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!(in_ready === 1'b1 && rst_n)) begin
            fails++;
            $display("FAIL handshake_timeout cyc=%0d got=in_ready_%0b want=1", cyc, in_ready);
        end else begin
            q.push_back('{data: d, mode: m, acc: cyc + 1});
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_mode  = 1'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain_timeout cyc=%0d got=%0d_pending want=0", cyc, q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        // reset with in_valid held high throughout
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'hF;
        in_mode  = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        send(4'b1010, 1'b0);          // parallel
        drain();
        send(4'b0110, 1'b1);          // serial
        drain();

        // in_valid toggling with 1111 during SHIFT must be ignored
        send(4'b1001, 1'b1);
        in_valid = 1'b1; in_data = 4'hF; in_mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        for (int i = 0; i < 10; i++) send(W'($urandom), 1'($urandom_range(0, 1)));
        drain();

        // reset mid-shift: word dropped, no done, counter cleared
        send(4'b1011, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 257 back-to-back words, counter wraps through 0 to 1
        for (int i = 0; i < 257; i++) send(W'($urandom), 1'($urandom_range(0, 1)));
        drain();
        chk("final_word_cnt", word_cnt, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
